// File: rtl/visu_mon.sv
// visu_mon: 640x480@60 VGA monitor showing 32 debug LEDs as an 8x4 grid of squares.
// Define VISUMON_GRID_EN to draw a 1-pixel grey border on each cell's first column and line.
module visu_mon #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_clkVideo,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic [17:0] i_debugInfo,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic        o_led
);

  localparam int H_TOTAL = H_ACTIVE + 160;
  localparam int V_TOTAL = V_ACTIVE + 45;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B  = HW'(H_ACTIVE + 16);
  localparam logic [HW-1:0] HS_E  = HW'(H_ACTIVE + 112);
  localparam logic [HW-1:0] CW    = HW'(80);
  localparam logic [HW-1:0] SQ_X0 = HW'(16);
  localparam logic [HW-1:0] SQ_X1 = HW'(63);

  localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_B  = VW'(V_ACTIVE + 10);
  localparam logic [VW-1:0] VS_E  = VW'(V_ACTIVE + 12);
  localparam logic [VW-1:0] CH    = VW'(120);
  localparam logic [VW-1:0] SQ_Y0 = VW'(36);
  localparam logic [VW-1:0] SQ_Y1 = VW'(83);

  logic [17:0]   arr_q [32];
  logic [17:0]   arr_d [32];
  logic          cs_prev_q, cs_prev_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          led_q, led_d;

  logic [2:0]    col;
  logic [1:0]    row;
  logic [HW-1:0] cx;
  logic [VW-1:0] cy;
  logic [12:0]   entry;
  logic          active;
  logic          in_sq;

  // Beyond the active area col/row may truncate; those pixels are blanked anyway.
  assign col    = 3'(hcnt_q / CW);
  assign row    = 2'(vcnt_q / CH);
  assign cx     = hcnt_q % CW;
  assign cy     = vcnt_q % CH;
  assign entry  = arr_q[{row, col}][12:0];
  assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign in_sq  = (cx >= SQ_X0) && (cx <= SQ_X1) &&
                  (cy >= SQ_Y0) && (cy <= SQ_Y1);

  always_comb begin
    arr_d = arr_q;
    if (cs_prev_q && !i_cs)
      arr_d[i_debugInfo[17:13]] = i_debugInfo;
    cs_prev_d = i_cs;

    hcnt_d = (hcnt_q == H_MAX) ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_MAX)
      vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + 1'b1;

    hsync_d = !((hcnt_q >= HS_B) && (hcnt_q < HS_E));
    vsync_d = !((vcnt_q >= VS_B) && (vcnt_q < VS_E));

    rgb_d = 12'h000;
    if (active && in_sq)
      rgb_d = entry[0] ? entry[12:1] : 12'h111;
`ifdef VISUMON_GRID_EN
    else if (active && (cx == '0 || cy == '0))
      rgb_d = 12'h444;
`endif

    led_d = 1'b0;
    for (int i = 0; i < 32; i++)
      led_d = led_d | arr_q[i][0];
  end

  always_ff @(posedge i_clkVideo) begin
    if (i_reset) begin
      arr_q     <= '{default: '0};
      cs_prev_q <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= '0;
      led_q     <= 1'b0;
    end else begin
      arr_q     <= arr_d;
      cs_prev_q <= cs_prev_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
      led_q     <= led_d;
    end
  end

  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_red   = rgb_q[11:8];
  assign o_green = rgb_q[7:4];
  assign o_blue  = rgb_q[3:0];
  assign o_led   = led_q;

endmodule

// File: tb/tb_visu_mon.sv
// tb_visu_mon: directed checks of visu_mon writes, sync timing and LED drawing.
// Uses a reduced 160x200 instance for pixel/vsync checks and a default one for hsync.
module tb_visu_mon;

  localparam int HT = 320;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [17:0] info;

  logic       hs, vs, led;
  logic [3:0] r, g, b;
  logic       hs0, vs0, led0;
  logic [3:0] r0, g0, b0;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  visu_mon #(.H_ACTIVE(160), .V_ACTIVE(200)) dut (
    .i_clkVideo (clk),
    .i_reset    (rst),
    .i_cs       (cs),
    .i_debugInfo(info),
    .o_hsync    (hs),
    .o_vsync    (vs),
    .o_red      (r),
    .o_green    (g),
    .o_blue     (b),
    .o_led      (led)
  );

  visu_mon dut_def (
    .i_clkVideo (clk),
    .i_reset    (rst),
    .i_cs       (cs),
    .i_debugInfo(info),
    .o_hsync    (hs0),
    .o_vsync    (vs0),
    .o_red      (r0),
    .o_green    (g0),
    .o_blue     (b0),
    .o_led      (led0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output for pixel (x,y) of the first frame is visible after edge y*HT+x+1.
  function automatic int pix(input int x, input int y);
    return y * HT + x + 1;
  endfunction

  task automatic at_cyc(input int n);
    checks++;
    if (cyc >= n) begin
      errs++;
      $display("FAIL schedule cyc=%0d target=%0d", cyc, n);
    end
    while (cyc < n) step();
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; cs = 1'b1; info = '0;
    repeat (3) step();
    checks++;
    if ({hs, vs, r, g, b, led} !== {2'b11, 12'h000, 1'b0}) begin
      errs++;
      $display("FAIL rst_out got=%b exp=%b", {hs, vs, r, g, b, led}, {2'b11, 12'h000, 1'b0});
    end
    checks++;
    if ({hs0, vs0, r0, g0, b0, led0} !== {2'b11, 12'h000, 1'b0}) begin
      errs++;
      $display("FAIL rst_out_def got=%b", {hs0, vs0, r0, g0, b0, led0});
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.arr_q[i] !== 18'h0) bad++;
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL rst_arr nonzero=%0d exp=0", bad);
    end
    // run briefly with cs high, then collide a falling cs with reset
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1; cs = 1'b0; info = {5'd3, 12'hF0F, 1'b1};
    step();
    checks++;
    if (dut.arr_q[3] !== 18'h0) begin
      errs++;
      $display("FAIL rst_collide got=%h exp=0", dut.arr_q[3]);
    end
    checks++;
    if ({hs, vs, r, g, b, led} !== {2'b11, 12'h000, 1'b0}) begin
      errs++;
      $display("FAIL rst_collide_out got=%b", {hs, vs, r, g, b, led});
    end
    step();
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if (dut.arr_q[3] !== 18'h0 || led !== 1'b0) begin
      errs++;
      $display("FAIL rst_low_cs got=%h led=%b exp=0/0", dut.arr_q[3], led);
    end
    cs = 1'b1;
    step();
  endtask

  task automatic test_hsync();
    at_cyc(176);
    checks++;
    if ({hs, vs} !== 2'b11) begin
      errs++; $display("FAIL hs_175 got=%b exp=11", {hs, vs});
    end
    at_cyc(177);
    checks++;
    if (hs !== 1'b0) begin
      errs++; $display("FAIL hs_176 got=%b exp=0", hs);
    end
    at_cyc(272);
    checks++;
    if (hs !== 1'b0) begin
      errs++; $display("FAIL hs_271 got=%b exp=0", hs);
    end
    at_cyc(273);
    checks++;
    if (hs !== 1'b1) begin
      errs++; $display("FAIL hs_272 got=%b exp=1", hs);
    end
    at_cyc(656);
    checks++;
    if (hs0 !== 1'b1) begin
      errs++; $display("FAIL hs0_655 got=%b exp=1", hs0);
    end
    at_cyc(657);
    checks++;
    if (hs0 !== 1'b0) begin
      errs++; $display("FAIL hs0_656 got=%b exp=0", hs0);
    end
    at_cyc(752);
    checks++;
    if (hs0 !== 1'b0) begin
      errs++; $display("FAIL hs0_751 got=%b exp=0", hs0);
    end
    at_cyc(753);
    checks++;
    if (hs0 !== 1'b1 || vs0 !== 1'b1) begin
      errs++; $display("FAIL hs0_752 got=%b%b exp=11", hs0, vs0);
    end
  endtask

  task automatic test_write_pulse();
    info = {5'd1, 12'hF0F, 1'b1};
    cs = 1'b1;
    repeat (5) step();
    checks++;
    if (dut.arr_q[1] !== 18'h0 || led !== 1'b0) begin
      errs++;
      $display("FAIL cs_high got=%h led=%b exp=0/0", dut.arr_q[1], led);
    end
    cs = 1'b0;
    step();
    checks++;
    if (dut.arr_q[1] !== {5'd1, 12'hF0F, 1'b1} || led !== 1'b0) begin
      errs++;
      $display("FAIL wr_pulse got=%h led=%b exp=%h/0", dut.arr_q[1], led, {5'd1, 12'hF0F, 1'b1});
    end
    cs = 1'b1;
    step();
    checks++;
    if (led !== 1'b1) begin
      errs++; $display("FAIL wr_led got=%b exp=1", led);
    end
  endtask

  task automatic test_held_low();
    info = {5'd1, 12'h000, 1'b0};
    step();
    cs = 1'b0;
    step();
    info = {5'd1, 12'h0F0, 1'b0};
    repeat (200) step();
    checks++;
    if (dut.arr_q[1] !== {5'd1, 12'h000, 1'b0} || led !== 1'b0) begin
      errs++;
      $display("FAIL held_low got=%h led=%b exp=%h/0", dut.arr_q[1], led, {5'd1, 12'h000, 1'b0});
    end
    cs = 1'b1;
    step();
    checks++;
    if (dut.arr_q[1] !== {5'd1, 12'h000, 1'b0}) begin
      errs++; $display("FAIL held_rise got=%h exp=%h", dut.arr_q[1], {5'd1, 12'h000, 1'b0});
    end
    cs = 1'b0;
    step();
    checks++;
    if (dut.arr_q[1] !== {5'd1, 12'h0F0, 1'b0}) begin
      errs++; $display("FAIL held_refall got=%h exp=%h", dut.arr_q[1], {5'd1, 12'h0F0, 1'b0});
    end
    cs = 1'b1;
    step();
  endtask

  task automatic test_pixels();
    logic [11:0] grid;
`ifdef VISUMON_GRID_EN
    grid = 12'h444;
`else
    grid = 12'h000;
`endif
    info = {5'd9, 12'h0F0, 1'b1};
    cs = 1'b0; step();
    cs = 1'b1; step();
    checks++;
    if (dut.arr_q[9] !== {5'd9, 12'h0F0, 1'b1} || led !== 1'b1) begin
      errs++; $display("FAIL wr9 got=%h led=%b", dut.arr_q[9], led);
    end
    at_cyc(pix(40, 60));
    checks++;
    if ({r, g, b} !== 12'h111) begin
      errs++; $display("FAIL pix_40_60 got=%h exp=111", {r, g, b});
    end
    at_cyc(pix(85, 125));
    checks++;
    if ({r, g, b} !== 12'h000) begin
      errs++; $display("FAIL pix_85_125 got=%h exp=000", {r, g, b});
    end
    at_cyc(pix(80, 130));
    checks++;
    if ({r, g, b} !== grid) begin
      errs++; $display("FAIL pix_80_130 got=%h exp=%h", {r, g, b}, grid);
    end
    at_cyc(pix(120, 155));
    checks++;
    if ({r, g, b} !== 12'h000) begin
      errs++; $display("FAIL pix_120_155 got=%h exp=000", {r, g, b});
    end
    at_cyc(pix(120, 156));
    checks++;
    if ({r, g, b} !== 12'h0F0) begin
      errs++; $display("FAIL pix_120_156 got=%h exp=0f0", {r, g, b});
    end
    at_cyc(pix(95, 170));
    checks++;
    if ({r, g, b} !== 12'h000) begin
      errs++; $display("FAIL pix_95_170 got=%h exp=000", {r, g, b});
    end
    at_cyc(pix(96, 170));
    checks++;
    if ({r, g, b} !== 12'h0F0) begin
      errs++; $display("FAIL pix_96_170 got=%h exp=0f0", {r, g, b});
    end
    at_cyc(pix(120, 170));
    checks++;
    if ({r, g, b} !== 12'h0F0) begin
      errs++; $display("FAIL pix_120_170 got=%h exp=0f0", {r, g, b});
    end
    at_cyc(pix(143, 170));
    checks++;
    if ({r, g, b} !== 12'h0F0) begin
      errs++; $display("FAIL pix_143_170 got=%h exp=0f0", {r, g, b});
    end
    at_cyc(pix(144, 170));
    checks++;
    if ({r, g, b} !== 12'h000) begin
      errs++; $display("FAIL pix_144_170 got=%h exp=000", {r, g, b});
    end
    at_cyc(pix(165, 170));
    checks++;
    if ({r, g, b} !== 12'h000) begin
      errs++; $display("FAIL pix_blank got=%h exp=000", {r, g, b});
    end
    info = {5'd9, 12'h0F0, 1'b0};
    cs = 1'b0; step();
    cs = 1'b1; step();
    checks++;
    if (led !== 1'b0) begin
      errs++; $display("FAIL led_off got=%b exp=0", led);
    end
    at_cyc(pix(120, 171));
    checks++;
    if ({r, g, b} !== 12'h111) begin
      errs++; $display("FAIL pix_120_171 got=%h exp=111", {r, g, b});
    end
  endtask

  task automatic test_vsync();
    at_cyc(210 * HT);
    checks++;
    if (vs !== 1'b1) begin
      errs++; $display("FAIL vs_209 got=%b exp=1", vs);
    end
    at_cyc(210 * HT + 1);
    checks++;
    if (vs !== 1'b0 || vs0 !== 1'b1) begin
      errs++; $display("FAIL vs_210 got=%b def=%b exp=0/1", vs, vs0);
    end
    at_cyc(212 * HT);
    checks++;
    if (vs !== 1'b0) begin
      errs++; $display("FAIL vs_211 got=%b exp=0", vs);
    end
    at_cyc(212 * HT + 1);
    checks++;
    if (vs !== 1'b1) begin
      errs++; $display("FAIL vs_212 got=%b exp=1", vs);
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_write_pulse();
    test_held_low();
    test_pixels();
    test_vsync();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/visu_mon.md
VISU_MON -- requirements
Module: visuMon

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL provide parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL provide port i_clkVideo, input, 1, the single 25.175/25 MHz pixel clock; all logic on its rising edge.
REQ-004 SHALL provide port i_reset, input, 1, reset; synchronous and active-high.
REQ-005 SHALL provide port i_cs, input, 1, active-low write strobe; a write fires on its high-to-low transition.
REQ-006 SHALL provide port i_debugInfo, input, 18, debugInfo_t packed as {ledNo[17:13], color[12:1], status[0]}.
REQ-007 SHALL provide port o_hsync, output, 1, horizontal sync, active-low.
REQ-008 SHALL provide port o_vsync, output, 1, vertical sync, active-low.
REQ-009 SHALL provide ports o_red, o_green, o_blue, output, 4 each, RGB444 pixel value.
REQ-010 SHALL provide port o_led, output, 1, high when any stored LED has status=1.
REQ-011 SHALL use color enum values as RGB444 codes: Black=12'h000, Green=12'h0F0, Magenta=12'hF0F (color[12:9]=R, [8:5]=G, [4:1]=B).

Function
REQ-012 SHALL hold a 32-entry register array arrDebugInfo of debugInfo_t, indexed by ledNo.
REQ-013 SHALL register i_cs each cycle (cs_prev) and, when cs_prev=1 and i_cs=0, write i_debugInfo into arrDebugInfo[i_debugInfo.ledNo].
REQ-014 SHALL make the written entry visible on the rising edge after the one that sampled the falling transition.
REQ-015 SHALL perform no write while i_cs stays low; i_debugInfo changes during a held-low i_cs are ignored until i_cs returns high and falls again.
REQ-016 SHALL store ledNo, color and status of a write unchanged; all 32 indices are valid.
REQ-017 SHALL generate 640x480@60 timing: 800 clocks/line (640 active, 16 front porch, 96 sync, 48 back porch) and 525 lines/frame (480 active, 10 front porch, 2 sync, 33 back porch).
REQ-018 SHALL wrap the horizontal counter from 799 to 0 and advance the vertical counter then; the vertical counter wraps from 524 to 0.
REQ-019 SHALL divide the active area into 8 columns x 4 rows of 80x120 cells; LED index = row*8 + col.
REQ-020 SHALL draw within each cell an LED square at cell offsets x 16..63, y 36..83 inclusive.
REQ-021 SHALL show the entry color inside the square when status=1, and 12'h111 when status=0.
REQ-022 SHALL output 12'h000 outside LED squares and during blanking.
REQ-023 SHALL register o_hsync, o_vsync and the RGB outputs, with sync and pixel aligned one clock after the counter values they derive from.
REQ-024 SHALL register o_led, reflecting arrDebugInfo one clock after an update.

Reset
REQ-025 SHALL, while i_reset=1 at a rising edge, clear all array entries to 0, clear both counters, and set cs_prev=0.
REQ-026 SHALL, while in reset, drive o_hsync=1, o_vsync=1, RGB=0 and o_led=0.
REQ-027 SHALL give reset priority over a simultaneous write.
REQ-028 SHALL, after reset, perform no write from a low i_cs until i_cs has been sampled high and then low.

Configuration
REQ-029 SHALL, with macro VISUMON_GRID_EN defined, draw a 1-pixel 12'h444 border on the first column and first line of every cell, lower priority than the LED square; without the macro, no border is drawn and those pixels follow REQ-022.

Verification
REQ-030 Reset release then idle with i_cs=1 -> all entries 0, o_led=0, first hsync low at hcount 656..751, vsync low on lines 490..491.
REQ-031 ledNo=1/Magenta/status=1 with i_cs held 1 -> entry 1 stays 0; after a 1->0->1 pulse -> entry 1 = {1, 12'hF0F, 1}, o_led=1.
REQ-032 Write {1, Black, 0}, keep i_cs low, change input to {1, Green, 0} for 200 clocks -> entry 1 remains Black; after a 1->0 transition -> entry 1 = Green.
REQ-033 Entry 9 = {9, Green, 1} -> pixel (x=120, y=170) outputs R=0, G=F, B=0; with status=0 it outputs 1,1,1; pixel (x=85, y=125) outputs 0 (grid off).
REQ-034 Falling i_cs in the same cycle as i_reset=1 -> no entry written and all outputs at reset values.
REQ-035 VISUMON_GRID_EN defined -> pixel (x=80, y=130) outputs 4,4,4; undefined -> 0,0,0.
